song_mem_arbiter: RTL and testbench

- Shares the single synchronous read port of the song BRAM between two requesters.
- Requester A is the audio sample fetcher in AV_block. It is real-time and has priority.
- Requester M is the note metadata fetcher in SC_block.
- The arbiter sequences one read at a time and returns the read data to the requester that won arbitration.
- A starvation counter guarantees M is served even under continuous A traffic.

---
 rtl/song_mem_arbiter_if.sv | 36 +++
 rtl/song_mem_arbiter.sv | 100 ++++++++++
 tb/tb_song_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/song_mem_arbiter_if.sv
// Song BRAM arbiter bus: two read requesters (audio, metadata) plus the memory read port.
// The arbiter takes the slave side; requesters and memory sit on the master side.
interface song_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              aud_req;
    logic [ADDR_W-1:0] aud_addr;
    logic              aud_ack;
    logic              aud_valid;
    logic [DATA_W-1:0] aud_data;

    logic              md_req;
    logic [ADDR_W-1:0] md_addr;
    logic              md_ack;
    logic              md_valid;
    logic [DATA_W-1:0] md_data;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              busy;

    modport slave (
        input  aud_req, aud_addr, md_req, md_addr, mem_data,
        output aud_ack, aud_valid, aud_data, md_ack, md_valid, md_data,
        output mem_en, mem_addr, busy
    );

    modport master (
        output aud_req, aud_addr, md_req, md_addr, mem_data,
        input  aud_ack, aud_valid, aud_data, md_ack, md_valid, md_data,
        input  mem_en, mem_addr, busy
    );
endinterface

// File: rtl/song_mem_arbiter.sv
// Shares the song BRAM read port between the audio fetcher (priority) and the metadata
// fetcher, one read in flight at a time, with a starvation limit protecting metadata.
//
// state     | meaning
// ST_IDLE   | no read in flight; arbitrate on incoming requests
// ST_ISSUE  | one cycle: mem_en, latched address, winner's ack
// ST_WAIT   | count down the memory read latency, capture read data on the last cycle
// ST_RETURN | winner's valid pulse; arbitrate again in the same cycle
module song_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic               clk,
    input  logic               reset,
    song_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              win_md_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        lat_q;
    logic [3:0]        starve_q;
    logic [DATA_W-1:0] aud_data_q;
    logic [DATA_W-1:0] md_data_q;

    logic arb_point;
    logic any_req;
    logic pick_md;
    logic grant;
    logic capture;

    assign arb_point = (state_q == ST_IDLE) || (state_q == ST_RETURN);
    assign any_req   = bus.aud_req || bus.md_req;
    // Audio keeps priority until metadata has watched MAX_STARVE audio grants go by.
    assign pick_md   = bus.md_req && (!bus.aud_req || (starve_q == 4'(MAX_STARVE)));
    assign grant     = arb_point && any_req;
    assign capture   = (state_q == ST_WAIT) && (lat_q == 3'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (lat_q == 3'd1) state_d = ST_RETURN;
            ST_RETURN: state_d = any_req ? ST_ISSUE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            win_md_q   <= 1'b0;
            addr_q     <= '0;
            lat_q      <= '0;
            starve_q   <= '0;
            aud_data_q <= '0;
            md_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                win_md_q <= pick_md;
                addr_q   <= pick_md ? bus.md_addr : bus.aud_addr;
                if (pick_md || !bus.md_req)
                    starve_q <= '0;
                else if (starve_q != 4'(MAX_STARVE))
                    starve_q <= starve_q + 4'd1;
            end
            if (state_q == ST_ISSUE)
                lat_q <= 3'(RD_LAT);
            else if (state_q == ST_WAIT)
                lat_q <= lat_q - 3'd1;
            if (capture) begin
                if (win_md_q)
                    md_data_q <= bus.mem_data;
                else
                    aud_data_q <= bus.mem_data;
            end
        end
    end

    assign bus.aud_ack   = (state_q == ST_ISSUE)  && !win_md_q;
    assign bus.md_ack    = (state_q == ST_ISSUE)  &&  win_md_q;
    assign bus.aud_valid = (state_q == ST_RETURN) && !win_md_q;
    assign bus.md_valid  = (state_q == ST_RETURN) &&  win_md_q;
    assign bus.aud_data  = aud_data_q;
    assign bus.md_data   = md_data_q;
    assign bus.mem_en    = (state_q == ST_ISSUE);
    assign bus.mem_addr  = addr_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_song_mem_arbiter.sv
// Bench for song_mem_arbiter: directed scenarios plus random requester traffic on an
// RD_LAT=2 instance, and a back-to-back audio sequence on an RD_LAT=1 instance.
module tb_song_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int L0 = 2;
    localparam int L1 = 1;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    song_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0();
    song_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();

    song_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L0), .MAX_STARVE(MS)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    song_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L1), .MAX_STARVE(MS)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Synchronous-read memories; non-enabled cycles push a poison word.
    logic [DW-1:0] pipe0 [L0];
    logic [DW-1:0] pipe1 [L1];
    always @(posedge clk) begin
        pipe0[0] <= bus0.mem_en ? mem_word(bus0.mem_addr) : 16'hDEAD;
        for (int i = 1; i < L0; i++) pipe0[i] <= pipe0[i-1];
        pipe1[0] <= bus1.mem_en ? mem_word(bus1.mem_addr) : 16'hDEAD;
    end
    assign bus0.mem_data = pipe0[L0-1];
    assign bus1.mem_data = pipe1[L1-1];

    // Reference model state (cycle numbers are absolute bench cycles)
    int            cyc;
    int            next_arb, busy_last, pend_ack, pend_valid, starve;
    bit            pend_who;
    logic [AW-1:0] pend_addr, exp_mem_addr;
    logic [DW-1:0] exp_aud_data, exp_md_data;

    logic [AW-1:0] a_q[$];
    logic [AW-1:0] m_q[$];
    logic [AW-1:0] a_idle_addr, m_idle_addr;

    bit  dut_grants[$];
    int  dut_ack_cyc[$];
    int  last_aud_ack, last_aud_valid, last_md_ack, last_md_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        next_arb     = cyc;
        busy_last    = -1;
        pend_ack     = -100;
        pend_valid   = -100;
        pend_who     = 1'b0;
        pend_addr    = '0;
        starve       = 0;
        exp_mem_addr = '0;
        exp_aud_data = '0;
        exp_md_data  = '0;
    endtask

    task automatic drive();
        bus0.aud_req  = (a_q.size() > 0);
        bus0.aud_addr = (a_q.size() > 0) ? a_q[0] : a_idle_addr;
        bus0.md_req   = (m_q.size() > 0);
        bus0.md_addr  = (m_q.size() > 0) ? m_q[0] : m_idle_addr;
    endtask

    // One cycle on dut0: drive, check against the model at negedge, advance the model.
    task automatic step();
        bit who;
        drive();
        @(negedge clk);
        if (cyc == pend_valid) begin
            if (pend_who) exp_md_data = mem_word(pend_addr);
            else          exp_aud_data = mem_word(pend_addr);
        end
        chk("aud_ack",   bus0.aud_ack,   (cyc == pend_ack)   && !pend_who);
        chk("md_ack",    bus0.md_ack,    (cyc == pend_ack)   &&  pend_who);
        chk("mem_en",    bus0.mem_en,    (cyc == pend_ack));
        chk("mem_addr",  bus0.mem_addr,  exp_mem_addr);
        chk("aud_valid", bus0.aud_valid, (cyc == pend_valid) && !pend_who);
        chk("md_valid",  bus0.md_valid,  (cyc == pend_valid) &&  pend_who);
        chk("aud_data",  bus0.aud_data,  exp_aud_data);
        chk("md_data",   bus0.md_data,   exp_md_data);
        chk("busy",      bus0.busy,      (cyc <= busy_last));

        if (bus0.aud_ack)   begin last_aud_ack = cyc; dut_grants.push_back(1'b0); dut_ack_cyc.push_back(cyc); end
        if (bus0.md_ack)    begin last_md_ack  = cyc; dut_grants.push_back(1'b1); dut_ack_cyc.push_back(cyc); end
        if (bus0.aud_valid) last_aud_valid = cyc;
        if (bus0.md_valid)  last_md_valid  = cyc;

        if (cyc >= next_arb && (bus0.aud_req || bus0.md_req)) begin
            who = bus0.md_req && (!bus0.aud_req || starve == MS);
            if (who || !bus0.md_req) starve = 0;
            else                     starve = (starve < MS) ? starve + 1 : MS;
            pend_who     = who;
            pend_addr    = who ? bus0.md_addr : bus0.aud_addr;
            pend_ack     = cyc + 1;
            pend_valid   = cyc + L0 + 2;
            next_arb     = cyc + L0 + 2;
            busy_last    = cyc + L0 + 2;
            exp_mem_addr = pend_addr;
        end

        if (bus0.aud_ack && a_q.size() > 0) void'(a_q.pop_front());
        if (bus0.md_ack  && m_q.size() > 0) void'(m_q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int t0;
        int g0;
        int n_ack;
        logic [9:0] pat;

        reset = 1'b1;
        a_idle_addr = '0;
        m_idle_addr = '0;
        cyc = 0;
        last_aud_ack = -1; last_aud_valid = -1; last_md_ack = -1; last_md_valid = -1;
        drive();
        bus1.aud_req = 1'b0; bus1.aud_addr = '0; bus1.md_req = 1'b0; bus1.md_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     bus0.busy,     1'b0);
        chk("rst_mem_en",   bus0.mem_en,   1'b0);
        chk("rst_mem_addr", bus0.mem_addr, 16'h0);
        chk("rst_aud_ack",  bus0.aud_ack,  1'b0);
        chk("rst_aud_data", bus0.aud_data, 16'h0);
        chk("rst_md_data",  bus0.md_data,  16'h0);
        chk("rst_busy1",    bus1.busy,     1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Single audio read of 0x0010
        a_q.push_back(16'h0010);
        t0 = cyc;
        repeat (6) step();
        chk("t1_ack_time",   last_aud_ack - t0,   1);
        chk("t1_valid_time", last_aud_valid - t0, 4);
        chk("t1_data",       bus0.aud_data,       16'hBEEF);
        repeat (2) step();

        // Both requesters rise together
        a_q.push_back(16'h0020);
        m_q.push_back(16'h0030);
        t0 = cyc;
        repeat (10) step();
        chk("t2_aud_ack",  last_aud_ack - t0,  1);
        chk("t2_md_ack",   last_md_ack - t0,   5);
        chk("t2_md_valid", last_md_valid - t0, 8);
        repeat (2) step();

        // Both held high: starvation forcing
        for (int i = 0; i < 8; i++) a_q.push_back(16'h1000 + 16'(i));
        for (int i = 0; i < 2; i++) m_q.push_back(16'h2000 + 16'(i));
        g0 = dut_grants.size();
        for (int k = 0; k < 60 && (a_q.size() > 0 || m_q.size() > 0); k++) step();
        repeat (4) step();
        chk("t3_grant_count", dut_grants.size() - g0, 10);
        pat = 10'b10_0001_0000;
        if (dut_grants.size() >= g0 + 10) begin
            for (int i = 0; i < 10; i++) chk("t3_order", dut_grants[g0+i], pat[i]);
            for (int i = 1; i < 10; i++) chk("t3_spacing", dut_ack_cyc[g0+i] - dut_ack_cyc[g0+i-1], 4);
        end

        // Metadata address changes right after ack
        m_idle_addr = 16'h0200;
        m_q.push_back(16'h0100);
        repeat (6) step();
        chk("t4_md_data", bus0.md_data, mem_word(16'h0100));
        repeat (2) step();

        // Reset in the middle of an audio read's WAIT
        a_q.push_back(16'h0123);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("t5_busy",     bus0.busy,      1'b0);
        chk("t5_mem_en",   bus0.mem_en,    1'b0);
        chk("t5_mem_addr", bus0.mem_addr,  16'h0);
        chk("t5_aud_data", bus0.aud_data,  16'h0);
        chk("t5_md_data",  bus0.md_data,   16'h0);
        chk("t5_valid",    bus0.aud_valid, 1'b0);
        a_q.delete();
        m_q.delete();
        m_idle_addr = '0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        repeat (4) step();
        m_q.push_back(16'h0777);
        t0 = cyc;
        repeat (5) step();
        chk("t5_md_ack_time", last_md_ack - t0, 1);

        // Random requester traffic with occasional withdrawals
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0 && a_q.size() < 3) a_q.push_back(16'($urandom));
            if ($urandom_range(0, 7) == 0 && m_q.size() < 3) m_q.push_back(16'($urandom));
            if ($urandom_range(0, 15) == 0 && pend_ack < cyc && a_q.size() == 1) void'(a_q.pop_front());
            if ($urandom_range(0, 15) == 0 && pend_ack < cyc && m_q.size() == 1) void'(m_q.pop_front());
            a_idle_addr = 16'($urandom);
            m_idle_addr = 16'($urandom);
            step();
        end
        for (int k = 0; k < 80 && (a_q.size() > 0 || m_q.size() > 0 || cyc <= busy_last); k++) step();
        chk("drain_empty", a_q.size() + m_q.size(), 0);

        // Back-to-back audio reads on the RD_LAT=1 instance
        bus1.aud_req  = 1'b1;
        bus1.aud_addr = 16'h0042;
        n_ack = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            chk("t6_ack",    bus1.aud_ack,   (c == 1 || c == 4 || c == 7));
            chk("t6_valid",  bus1.aud_valid, (c == 3 || c == 6 || c == 9));
            chk("t6_md_ack", bus1.md_ack,    1'b0);
            if (bus1.aud_valid) chk("t6_data", bus1.aud_data, mem_word(16'h0042));
            if (bus1.aud_ack) n_ack++;
            @(posedge clk);
            #1;
            if (n_ack == 3) bus1.aud_req = 1'b0;
        end
        chk("t6_ack_count", n_ack, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
